// File: rtl/ising_pkg.sv
// Shared types and helpers for the Ising step scheduler.
package ising_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        COMPUTE = 3'd2,
        UPDATE  = 3'd3,
        FINISH  = 3'd4
    } state_t;

    localparam int DEFAULT_N          = 16;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_FRAC_BITS  = 16;

    // Operands arrive sign-extended to 64 bits; the result is clamped to a signed 'width'-bit range.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        width
    );
        logic signed [63:0] sum;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        sum   = a + b;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (sum > max_v) begin
            return max_v;
        end else if (sum < min_v) begin
            return min_v;
        end else begin
            return sum;
        end
    endfunction

endpackage

// File: rtl/ising_pair_counter.sv
// Row-major (i,j) coupling-pair walker with first/last/wrap flags.
// ISING_SKIP_DIAG_EN removes the j==i pairs from every row.
module ising_pair_counter
    import ising_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [IDX_W-1:0] pair_i,
    output logic [IDX_W-1:0] pair_j,
    output logic             first,
    output logic             last,
    output logic             last_pair
);

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(N - 1);
`ifdef ISING_SKIP_DIAG_EN
    localparam logic [IDX_W-1:0] ROW0_FIRST = IDX_W'(1);
`else
    localparam logic [IDX_W-1:0] ROW0_FIRST = '0;
`endif

    logic [IDX_W-1:0] next_i;
    logic [IDX_W-1:0] next_j;
    logic [IDX_W-1:0] row_first;
    logic [IDX_W-1:0] row_last;

    always_comb begin
        next_i = pair_i;
        if (last) begin
            next_i = last_pair ? '0 : pair_i + 1'b1;
        end
    end

    // Bounds of the row being entered; only the diagonal rows at the ends shift them.
`ifdef ISING_SKIP_DIAG_EN
    assign row_first = (next_i == '0) ? IDX_W'(1) : '0;
    assign row_last  = (next_i == MAX_IDX) ? IDX_W'(N - 2) : MAX_IDX;
`else
    assign row_first = '0;
    assign row_last  = MAX_IDX;
`endif

    always_comb begin
        next_j = pair_j + 1'b1;
        if (last) begin
            next_j = row_first;
        end
`ifdef ISING_SKIP_DIAG_EN
        else if (pair_j + 1'b1 == pair_i) begin
            next_j = pair_j + IDX_W'(2);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pair_i    <= '0;
            pair_j    <= '0;
            first     <= 1'b0;
            last      <= 1'b0;
            last_pair <= 1'b0;
        end else if (clear) begin
            pair_i    <= '0;
            pair_j    <= ROW0_FIRST;
            first     <= 1'b1;
            last      <= (ROW0_FIRST == MAX_IDX);
            last_pair <= 1'b0;
        end else if (advance) begin
            pair_i    <= next_i;
            pair_j    <= next_j;
            first     <= (next_j == row_first);
            last      <= (next_j == row_last);
            last_pair <= (next_j == row_last) && (next_i == MAX_IDX);
        end
    end

endmodule

// File: rtl/ising_step_scheduler.sv
// Sequencing controller for the oscillator Ising solver: INIT/COMPUTE/UPDATE loop plus time integration.
// Optional macro ISING_SKIP_DIAG_EN drops the diagonal coupling pairs (handled in ising_pair_counter).
module ising_step_scheduler
    import ising_pkg::*;
#(
    parameter int N          = DEFAULT_N,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FRAC_BITS  = DEFAULT_FRAC_BITS,
    parameter int IDX_W      = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] stop_time,
    input  logic [DATA_WIDTH-1:0] delta_t,
    output logic                  init_valid,
    input  logic                  init_ready,
    output logic [IDX_W-1:0]      init_idx,
    output logic                  mac_valid,
    input  logic                  mac_ready,
    output logic [IDX_W-1:0]      mac_i,
    output logic [IDX_W-1:0]      mac_j,
    output logic                  mac_first,
    output logic                  mac_last,
    output logic                  upd_valid,
    input  logic                  upd_ready,
    output logic [IDX_W-1:0]      upd_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic [DATA_WIDTH-1:0] sim_time,
    output logic [15:0]           step_count
);

    if (N < 2 || N > 64 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("ising_step_scheduler: N must be a power of two in 2..64");
    end
    if (FRAC_BITS >= DATA_WIDTH) begin : g_bad_frac
        $error("ising_step_scheduler: FRAC_BITS must be below DATA_WIDTH");
    end

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(N - 1);

    state_t                  state;
    logic signed [DATA_WIDTH-1:0] stop_q;
    logic signed [DATA_WIDTH-1:0] delta_q;
    logic signed [DATA_WIDTH-1:0] time_q;
    logic signed [DATA_WIDTH-1:0] new_time;
    logic [15:0]             steps_q;
    logic [IDX_W-1:0]        init_q;
    logic [IDX_W-1:0]        upd_q;
    logic                    init_v;
    logic                    mac_v;
    logic                    upd_v;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;
    logic                    start_accept;
    logic                    mac_accept;
    logic                    pair_last;

    assign start_accept = (state == IDLE) && start;
    assign mac_accept   = (state == COMPUTE) && mac_v && mac_ready;
    assign new_time     = DATA_WIDTH'(sat_add(64'(time_q), 64'(delta_q), DATA_WIDTH));

    ising_pair_counter #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pairs (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_accept),
        .advance   (mac_accept),
        .pair_i    (mac_i),
        .pair_j    (mac_j),
        .first     (mac_first),
        .last      (mac_last),
        .last_pair (pair_last)
    );

    // Each state raises the next channel's valid on the same edge that retires the last beat, so no bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            stop_q  <= '0;
            delta_q <= '0;
            time_q  <= '0;
            steps_q <= '0;
            init_q  <= '0;
            upd_q   <= '0;
            init_v  <= 1'b0;
            mac_v   <= 1'b0;
            upd_v   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        stop_q  <= stop_time;
                        delta_q <= delta_t;
                        time_q  <= '0;
                        steps_q <= '0;
                        err_q   <= 1'b0;
                        init_q  <= '0;
                        upd_q   <= '0;
                        init_v  <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= INIT;
                    end
                end
                INIT: begin
                    if (init_v && init_ready) begin
                        if (init_q == MAX_IDX) begin
                            init_v <= 1'b0;
                            init_q <= '0;
                            if (stop_q[DATA_WIDTH-1] || stop_q == '0) begin
                                done_q <= 1'b1;
                                state  <= FINISH;
                            end else if (delta_q[DATA_WIDTH-1] || delta_q == '0) begin
                                err_q  <= 1'b1;
                                done_q <= 1'b1;
                                state  <= FINISH;
                            end else begin
                                mac_v <= 1'b1;
                                state <= COMPUTE;
                            end
                        end else begin
                            init_q <= init_q + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (mac_accept && pair_last) begin
                        mac_v <= 1'b0;
                        upd_v <= 1'b1;
                        upd_q <= '0;
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    if (upd_v && upd_ready) begin
                        if (upd_q == MAX_IDX) begin
                            upd_v  <= 1'b0;
                            upd_q  <= '0;
                            time_q <= new_time;
                            if (steps_q != 16'hFFFF) begin
                                steps_q <= steps_q + 16'd1;
                            end
                            if (new_time >= stop_q) begin
                                done_q <= 1'b1;
                                state  <= FINISH;
                            end else begin
                                mac_v <= 1'b1;
                                state <= COMPUTE;
                            end
                        end else begin
                            upd_q <= upd_q + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign init_valid = init_v;
    assign init_idx   = init_q;
    assign mac_valid  = mac_v;
    assign upd_valid  = upd_v;
    assign upd_idx    = upd_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cfg_err    = err_q;
    assign sim_time   = time_q;
    assign step_count = steps_q;

endmodule

// File: tb/tb_ising_step_scheduler.sv
// Randomized self-checking bench for ising_step_scheduler against a beat-list reference model.
module tb_ising_step_scheduler;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;
`ifdef ISING_SKIP_DIAG_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] stop_time;
    logic [DW-1:0] delta_t;
    logic          init_valid, init_ready;
    logic [IW-1:0] init_idx;
    logic          mac_valid, mac_ready;
    logic [IW-1:0] mac_i, mac_j;
    logic          mac_first, mac_last;
    logic          upd_valid, upd_ready;
    logic [IW-1:0] upd_idx;
    logic          busy, done, cfg_err;
    logic [DW-1:0] sim_time;
    logic [15:0]   step_count;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        int chan;
        int a;
        int b;
        int first;
        int last;
    } beat_t;

    beat_t exp_q[$];

    always #5 clk = ~clk;

    ising_step_scheduler #(.N(N), .DATA_WIDTH(DW), .FRAC_BITS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop_time  (stop_time),
        .delta_t    (delta_t),
        .init_valid (init_valid),
        .init_ready (init_ready),
        .init_idx   (init_idx),
        .mac_valid  (mac_valid),
        .mac_ready  (mac_ready),
        .mac_i      (mac_i),
        .mac_j      (mac_j),
        .mac_first  (mac_first),
        .mac_last   (mac_last),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_idx    (upd_idx),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .sim_time   (sim_time),
        .step_count (step_count)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] packBeat(input int chan, input int a, input int b, input int first, input int last);
        return 32'(chan * 16777216 + a * 65536 + b * 256 + first * 2 + last);
    endfunction

    function automatic logic [63:0] packAll();
        return {init_valid, init_idx, mac_valid, mac_i, mac_j, mac_first, mac_last,
                upd_valid, upd_idx, busy, done, cfg_err, sim_time, step_count};
    endfunction

    // Reference: the full ordered list of beats a run must issue, plus its final time/steps/error.
    task automatic buildModel(input logic [31:0] st, input logic [31:0] dt,
                              output int steps, output logic [31:0] final_t, output logic err);
        longint s;
        longint d;
        longint t;
        s = longint'($signed(st));
        d = longint'($signed(dt));
        t = 0;
        steps = 0;
        err = 1'b0;
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back('{0, i, 0, 0, 0});
        if (s <= 0) begin
            err = 1'b0;
        end else if (d <= 0) begin
            err = 1'b1;
        end else begin
            while (t < s) begin
                for (int i = 0; i < N; i++) begin
                    int js[$];
                    for (int j = 0; j < N; j++) if (!(SKIP && i == j)) js.push_back(j);
                    for (int k = 0; k < js.size(); k++)
                        exp_q.push_back('{1, i, js[k], int'(k == 0), int'(k == js.size() - 1)});
                end
                for (int i = 0; i < N; i++) exp_q.push_back('{2, i, 0, 0, 0});
                t = t + d;
                if (t > 64'sd2147483647) t = 64'sd2147483647;
                steps++;
            end
        end
        final_t = 32'(t);
    endtask

    // ready_mode: 0 all ready, 1 random readies, 2 mac_ready low 5 cycles at pair (1,2).
    task automatic applyStimulus(input logic [31:0] st, input logic [31:0] dt, input int ready_mode, input int noise);
        int          steps;
        logic [31:0] exp_t;
        logic        err;
        int          total;
        int          cyc;
        int          stalls;
        int          bp_left;
        bit          bp_used;
        bit          seen_done;
        logic        v [3];
        logic        r [3];
        logic [31:0] p [3];
        logic        hold [3];
        logic [31:0] hold_p [3];
        beat_t       e;

        buildModel(st, dt, steps, exp_t, err);
        total = exp_q.size();
        @(posedge clk); #1;
        stop_time = st;
        delta_t   = dt;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; stalls = 0; bp_left = 0; bp_used = 0; seen_done = 0;
        for (int c = 0; c < 3; c++) begin hold[c] = 1'b0; hold_p[c] = '0; end

        while (!seen_done && cyc < 3000) begin
            case (ready_mode)
                1: begin
                    init_ready = ($urandom_range(0, 3) != 0);
                    mac_ready  = ($urandom_range(0, 3) != 0);
                    upd_ready  = ($urandom_range(0, 3) != 0);
                end
                2: begin
                    if (!bp_used && mac_valid && mac_i == 2'd1 && mac_j == 2'd2) begin
                        bp_used = 1;
                        bp_left = 5;
                    end
                    init_ready = 1'b1;
                    upd_ready  = 1'b1;
                    mac_ready  = (bp_left == 0);
                    if (bp_left > 0) bp_left--;
                end
                default: begin
                    init_ready = 1'b1;
                    mac_ready  = 1'b1;
                    upd_ready  = 1'b1;
                end
            endcase
            if (noise != 0) begin
                start     = 1'($urandom_range(0, 1));
                stop_time = $urandom;
                delta_t   = $urandom;
            end
            @(negedge clk);
            cyc++;
            v[0] = init_valid; r[0] = init_ready; p[0] = packBeat(0, int'(init_idx), 0, 0, 0);
            v[1] = mac_valid;  r[1] = mac_ready;
            p[1] = packBeat(1, int'(mac_i), int'(mac_j), int'(mac_first), int'(mac_last));
            v[2] = upd_valid;  r[2] = upd_ready;  p[2] = packBeat(2, int'(upd_idx), 0, 0, 0);
            checkOutput("single_valid", 64'((v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2])), 64'd0);
            checkOutput("busy_high", 64'(busy), 64'd1);
            for (int c = 0; c < 3; c++) begin
                if (hold[c]) begin
                    checkOutput("hold_valid", 64'(v[c]), 64'd1);
                    checkOutput("hold_payload", 64'(p[c]), 64'(hold_p[c]));
                end
                if (v[c] && r[c]) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("extra_beat", 64'(p[c]), 64'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("beat", 64'(p[c]), 64'(packBeat(e.chan, e.a, e.b, e.first, e.last)));
                    end
                end
                hold[c]   = v[c] && !r[c];
                hold_p[c] = p[c];
                if (hold[c]) stalls++;
            end
            if (done) begin
                seen_done = 1;
            end else begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;

        if (!seen_done) begin
            checkOutput("done_timeout", 64'd0, 64'd1);
        end else begin
            checkOutput("done_cycle", 64'(cyc), 64'(total + stalls + 1));
            checkOutput("step_count", 64'(step_count), 64'(steps));
            checkOutput("sim_time", 64'(sim_time), 64'(exp_t));
            checkOutput("cfg_err", 64'(cfg_err), 64'(err));
            checkOutput("beats_left", 64'(exp_q.size()), 64'd0);
            if (ready_mode == 2 && steps > 0) checkOutput("bp_stalls", 64'(stalls), 64'd5);
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput("idle_busy", 64'(busy), 64'd0);
            checkOutput("idle_done", 64'(done), 64'd0);
            checkOutput("sticky_err", 64'(cfg_err), 64'(err));
        end
    endtask

    task automatic applyResetMidRun();
        int k;
        int budget;
        int dcount;
        init_ready = 1'b1;
        mac_ready  = 1'b1;
        upd_ready  = 1'b1;
        @(posedge clk); #1;
        stop_time = 32'h0003_0000;
        delta_t   = 32'h0001_0000;
        start     = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        k      = $urandom_range(3, 30);
        budget = 0;
        while (k > 0 && budget < 500) begin
            @(posedge clk); #1;
            budget++;
            if (mac_valid) k--;
        end
        checkOutput("reached_compute", 64'(mac_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_mid_run", packAll(), 64'd0);
        dcount = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dcount++;
        end
        checkOutput("no_done_after_abort", 64'(dcount), 64'd0);
        checkOutput("abort_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [31:0] st;
        logic [31:0] dt;
        rst        = 1'b1;
        start      = 1'b0;
        stop_time  = '0;
        delta_t    = '0;
        init_ready = 1'b0;
        mac_ready  = 1'b0;
        upd_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_state", packAll(), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        applyStimulus(32'h0003_0000, 32'h0001_0000, 0, 0);
        applyStimulus(32'h0003_0000, 32'h0001_0000, 2, 0);
        applyStimulus(32'h0000_0000, 32'h0001_0000, 0, 0);
        applyStimulus(32'h0000_0001, 32'h0000_0000, 0, 0);
        applyStimulus(32'h0003_0000, 32'h0001_0000, 0, 0);
        applyStimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 0);
        applyStimulus(32'h7FFF_FFFF, 32'h4000_0001, 1, 0);
        applyStimulus(32'hFFFF_0000, 32'h0001_0000, 1, 0);
        applyResetMidRun();
        applyStimulus(32'h0003_0000, 32'h0001_0000, 1, 1);
        for (int n = 0; n < 8; n++) begin
            st = 32'($urandom_range(1, 32'h0004_0000));
            dt = 32'($urandom_range(32'h0000_8000, 32'h0003_0000));
            if ($urandom_range(0, 5) == 0) dt = -dt;
            applyStimulus(st, dt, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
